control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Fetch/decode/execute controller that drives every control input of the ALU_System datapath and reads its IROut and ALUOutFlag.
//  Each instruction is 16 bits and is fetched as two bytes into the IR; the sequencer then decodes it and executes it in one or two cycles.
//  The datapath itself holds no sequencing logic; this block is the initiator for all RF, ARF, IR and memory traffic.
// PARAMETERS
//  RESET_PC  8'h00  value loaded into PC on the first cycle after reset
// PORTS
//  Clock        in   1   system clock; all state updates on rising edge
//  Reset        in   1   asynchronous, active-high; clears FSM to S_RST
//  IROut        in   16  datapath instruction register
//  ALUOutFlag   in   4   {Z,C,N,O} from ALU
//  RF_OutASel, RF_OutBSel  out  3  RF read ports: 0..3=R1..R4
//  RF_FunSel, ARF_FunSel, IR_Funsel  out  2  00 clear, 01 load, 10 dec, 11 inc
//  RF_RSel      out  4   one-hot write enable, bit3=R1 .. bit0=R4
//  RF_TSel      out  4   temp regs, always 4'b0000
//  ALU_FunSel   out  4   ALU operation
//  ARF_OutCSel, ARF_OutDSel  out  2  00 AR, 01 SP, 1x PC
//  ARF_RegSel   out  4   one-hot enable, bit3=PC, bit2=AR, bit1=SP, bit0 unused
//  IR_LH        out  1   0 = low byte, 1 = high byte
//  IR_Enable    out  1   IR write enable
//  Mem_WR       out  1   1 = write
//  Mem_CS       out  1   0 = selected
//  MuxASel, MuxBSel  out  2  00 ALU, 01 Mem, 10 IR[7:0], 11 ARF OutC
//  MuxCSel      out  1   0 = RF OutA, 1 = ARF OutC
//  Halted       out  1   1 while in S_HALT
// BEHAVIOUR
//  All outputs are registered off the FSM decode and are idle whenever the FSM is not actively driving them.
//  Idle values: every enable/RSel/RegSel = 0, Mem_CS = 1, Mem_WR = 0, every select = 0, Halted = 0. Idle is also the reset value.
//  Memory reads are combinational. Address always comes from ARF OutD.
//  FSM states: S_RST -> S_FL -> S_FH -> S_DEC -> S_EX1 [-> S_EX2] -> S_FL; S_HALT is terminal.
//  S_RST: PC <= RESET_PC via MuxB=IR path disabled. PC is cleared (FunSel 00) and then incremented RESET_PC times. If RESET_PC == 0, the clear alone suffices.
//  S_FL: ARF_OutDSel = PC; Mem_CS = 0; IR_Enable = 1; IR_LH = 0; IR_Funsel = 01; PC incremented (RegSel[3], FunSel 11).
//  S_FH: same as S_FL, but IR_LH = 1.
//  S_DEC: no datapath writes. Decodes IROut[15:12] = op, [11:10] = Rd, [9:8] = Rs1, [7:6] = Rs2, [7:0] = imm.
//  Ops 0x0-0x8 (AND, OR, NOT, ADD, SUB, LSR, LSL, INC, DEC), in S_EX1:
//    - MuxCSel = 0, OutA = Rs1, OutB = Rs2, ALU_FunSel from a fixed table.
//    - MuxA = ALU, RF load Rd.
//    - 1 execute cycle.
//  0x9 BRA: PC <= imm (MuxB = IR, ARF load PC). 1 cycle.
//  0xA BNE: as BRA if ALUOutFlag[3] == 0 as sampled in S_DEC; otherwise no write.
//  0xB LDI: Rd <= imm (MuxA = IR). 0xC LDM: Rd <= M[AR] (OutDSel = AR, MuxA = Mem).
//  0xD ST: S_EX1 routes Rd through the ALU as pass-A. S_EX2 asserts Mem_CS = 0, Mem_WR = 1, with address AR. Two cycles.
//  0xE MAR: AR <= imm. 0xF HLT: enter S_HALT; outputs idle; Halted = 1 until Reset.
//  Instruction latency: 4 cycles (FL, FH, DEC, EX1); ST takes 5.
//  PC wraps 8'hFF -> 8'h00 silently, including mid-fetch.
//  Reset asserted in any state, including mid-ST: outputs go idle asynchronously, so no partial write occurs. Execution restarts at S_RST.
//  Flags are consumed only in S_DEC. Flags changed by the previous instruction's EX are therefore visible.
// CONFIGURATION
//  CU_SINGLE_STEP_EN defined:
//    - Adds input Step (1) and output Ready (1).
//    - Ready = 1 only in S_FL while waiting. The FSM holds S_FL with outputs idle until Step is sampled 1, then performs the S_FL actions.
//    - Step held high runs at full speed.
//  CU_SINGLE_STEP_EN undefined: ports absent; S_FL never stalls.
// TESTING
//  1. Reset mid-S_FH -> all outputs idle immediately; Mem_CS = 1; next fetch starts at PC = RESET_PC.
//  2. Memory {0xB4,0x05} (LDI R2,5) -> at EX1 RF_RSel = 4'b0100, MuxASel = 10; 4 cycles total.
//  3. LDI R1,3; LDI R2,4; ADD R3,R1,R2 -> EX1 OutASel = 0, OutBSel = 1, RF_RSel = 4'b0010; R3 = 7.
//  4. BNE 0x20 with Z = 1 -> no PC load; with Z = 0 -> ARF_RegSel = 4'b1000, MuxBSel = 10; next fetch Address = 0x20.
//  5. MAR 0x40; ST R1 -> EX2 Mem_WR = 1, Mem_CS = 0, ARF_OutDSel = 00; M[0x40] = R1.
//  6. PC = 0xFF fetch -> high byte is read from 0x00. HLT -> Halted = 1, outputs stay idle for 20 cycles.

Source files
------------

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer driving every control input of the ALU_System datapath.
// Optional build macro CU_SINGLE_STEP_EN adds i_step/o_ready and stalls each fetch until stepped.
module control_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst,
`ifdef CU_SINGLE_STEP_EN
  input  logic        i_step,
  output logic        o_ready,
`endif
  input  logic [15:0] i_ir_out,
  input  logic [3:0]  i_alu_out_flag,
  output logic [2:0]  o_rf_out_a_sel,
  output logic [2:0]  o_rf_out_b_sel,
  output logic [1:0]  o_rf_fun_sel,
  output logic [3:0]  o_rf_r_sel,
  output logic [3:0]  o_rf_t_sel,
  output logic [3:0]  o_alu_fun_sel,
  output logic [1:0]  o_arf_out_c_sel,
  output logic [1:0]  o_arf_out_d_sel,
  output logic [1:0]  o_arf_fun_sel,
  output logic [3:0]  o_arf_reg_sel,
  output logic        o_ir_lh,
  output logic        o_ir_enable,
  output logic [1:0]  o_ir_fun_sel,
  output logic        o_mem_wr,
  output logic        o_mem_cs,
  output logic [1:0]  o_mux_a_sel,
  output logic [1:0]  o_mux_b_sel,
  output logic        o_mux_c_sel,
  output logic        o_halted
);

  // state  | meaning
  // S_RST  | clear PC, then increment it RESET_PC times
  // S_FL   | fetch low instruction byte (or wait for step)
  // S_FH   | fetch high instruction byte
  // S_DEC  | decode IROut, sample flags
  // S_EX1  | execute
  // S_EX2  | store write cycle
  // S_HALT | terminal until reset
  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_FL   = 3'd1;
  localparam logic [2:0] S_FH   = 3'd2;
  localparam logic [2:0] S_DEC  = 3'd3;
  localparam logic [2:0] S_EX1  = 3'd4;
  localparam logic [2:0] S_EX2  = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_NOT = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_LSR = 4'h5;
  localparam logic [3:0] OP_LSL = 4'h6;
  localparam logic [3:0] OP_INC = 4'h7;
  localparam logic [3:0] OP_DEC = 4'h8;
  localparam logic [3:0] OP_BRA = 4'h9;
  localparam logic [3:0] OP_BNE = 4'hA;
  localparam logic [3:0] OP_LDI = 4'hB;
  localparam logic [3:0] OP_LDM = 4'hC;
  localparam logic [3:0] OP_ST  = 4'hD;
  localparam logic [3:0] OP_MAR = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] FUN_CLR  = 2'b00;
  localparam logic [1:0] FUN_LOAD = 2'b01;
  localparam logic [1:0] FUN_INC  = 2'b11;

  localparam logic [3:0] REG_PC = 4'b1000;
  localparam logic [3:0] REG_AR = 4'b0100;

  localparam logic [1:0] OUTD_AR = 2'b00;
  localparam logic [1:0] OUTD_PC = 2'b10;

  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_MEM = 2'b01;
  localparam logic [1:0] MUX_IR  = 2'b10;

  localparam logic [3:0] ALU_PASS_A = 4'b0000;

  typedef struct packed {
    logic [2:0] rf_out_a_sel;
    logic [2:0] rf_out_b_sel;
    logic [1:0] rf_fun_sel;
    logic [3:0] rf_r_sel;
    logic [3:0] alu_fun_sel;
    logic [1:0] arf_out_c_sel;
    logic [1:0] arf_out_d_sel;
    logic [1:0] arf_fun_sel;
    logic [3:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_enable;
    logic [1:0] ir_fun_sel;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
    logic       halted;
  } ctl_t;

  logic [2:0] r_state, w_state;
  logic       r_sub, w_sub;
  logic [7:0] r_cnt, w_cnt;
  logic [1:0] r_rd, w_rd;
  logic       r_st, w_st;
  logic       w_to_fetch;
  ctl_t       r_ctl, w_ctl;
  logic       w_unused_bits;

  function automatic ctl_t f_idle();
    ctl_t c;
    c        = '0;
    c.mem_cs = 1'b1;
    return c;
  endfunction

  function automatic ctl_t f_fetch(input logic lh);
    ctl_t c;
    c               = f_idle();
    c.arf_out_d_sel = OUTD_PC;
    c.mem_cs        = 1'b0;
    c.ir_enable     = 1'b1;
    c.ir_lh         = lh;
    c.ir_fun_sel    = FUN_LOAD;
    c.arf_reg_sel   = REG_PC;
    c.arf_fun_sel   = FUN_INC;
    return c;
  endfunction

  function automatic logic [3:0] f_rf_onehot(input logic [1:0] rd);
    return 4'b1000 >> rd;
  endfunction

  function automatic logic [3:0] f_alu_code(input logic [3:0] op);
    logic [3:0] code;
    case (op)
      OP_AND:  code = 4'b0111;
      OP_OR:   code = 4'b1000;
      OP_NOT:  code = 4'b0010;
      OP_ADD:  code = 4'b0100;
      OP_SUB:  code = 4'b0110;
      OP_LSR:  code = 4'b1011;
      OP_LSL:  code = 4'b1010;
      OP_INC:  code = 4'b1100;
      OP_DEC:  code = 4'b1101;
      default: code = ALU_PASS_A;
    endcase
    return code;
  endfunction

  function automatic ctl_t f_exec(input logic [15:0] ir, input logic z);
    ctl_t       c;
    logic [3:0] op;
    logic [1:0] rd;
    op = ir[15:12];
    rd = ir[11:10];
    c  = f_idle();
    case (op)
      OP_AND, OP_OR, OP_NOT, OP_ADD, OP_SUB, OP_LSR, OP_LSL, OP_INC, OP_DEC: begin
        c.mux_c_sel    = 1'b0;
        c.rf_out_a_sel = {1'b0, ir[9:8]};
        c.rf_out_b_sel = {1'b0, ir[7:6]};
        c.alu_fun_sel  = f_alu_code(op);
        c.mux_a_sel    = MUX_ALU;
        c.rf_r_sel     = f_rf_onehot(rd);
        c.rf_fun_sel   = FUN_LOAD;
      end
      OP_BRA, OP_BNE: begin
        // BNE only branches when Z was clear at decode
        if (op == OP_BRA || !z) begin
          c.mux_b_sel   = MUX_IR;
          c.arf_reg_sel = REG_PC;
          c.arf_fun_sel = FUN_LOAD;
        end
      end
      OP_LDI: begin
        c.mux_a_sel  = MUX_IR;
        c.rf_r_sel   = f_rf_onehot(rd);
        c.rf_fun_sel = FUN_LOAD;
      end
      OP_LDM: begin
        c.arf_out_d_sel = OUTD_AR;
        c.mem_cs        = 1'b0;
        c.mux_a_sel     = MUX_MEM;
        c.rf_r_sel      = f_rf_onehot(rd);
        c.rf_fun_sel    = FUN_LOAD;
      end
      OP_ST: begin
        c.mux_c_sel    = 1'b0;
        c.rf_out_a_sel = {1'b0, rd};
        c.alu_fun_sel  = ALU_PASS_A;
      end
      OP_MAR: begin
        c.mux_b_sel   = MUX_IR;
        c.arf_reg_sel = REG_AR;
        c.arf_fun_sel = FUN_LOAD;
      end
      default: c = f_idle();
    endcase
    return c;
  endfunction

  // Rd stays on the ALU pass-A path so write data is stable during the memory strobe
  function automatic ctl_t f_store(input logic [1:0] rd);
    ctl_t c;
    c               = f_idle();
    c.mux_c_sel     = 1'b0;
    c.rf_out_a_sel  = {1'b0, rd};
    c.alu_fun_sel   = ALU_PASS_A;
    c.arf_out_d_sel = OUTD_AR;
    c.mem_cs        = 1'b0;
    c.mem_wr        = 1'b1;
    return c;
  endfunction

`ifdef CU_SINGLE_STEP_EN
  logic r_ready, w_ready;
`endif

  always_comb begin
    w_state    = r_state;
    w_sub      = r_sub;
    w_cnt      = r_cnt;
    w_rd       = r_rd;
    w_st       = r_st;
    w_ctl      = f_idle();
    w_to_fetch = 1'b0;
`ifdef CU_SINGLE_STEP_EN
    w_ready    = 1'b0;
`endif
    case (r_state)
      S_RST: begin
        if (!r_sub) begin
          w_sub             = 1'b1;
          w_ctl.arf_reg_sel = REG_PC;
          w_ctl.arf_fun_sel = FUN_CLR;
        end else if (r_cnt != 8'h00) begin
          w_cnt             = r_cnt - 8'h01;
          w_ctl.arf_reg_sel = REG_PC;
          w_ctl.arf_fun_sel = FUN_INC;
        end else begin
          w_to_fetch = 1'b1;
        end
      end
      S_FL: begin
        if (r_sub) begin
          w_to_fetch = 1'b1;
        end else begin
          w_state = S_FH;
          w_ctl   = f_fetch(1'b1);
        end
      end
      S_FH: w_state = S_DEC;
      S_DEC: begin
        w_rd = i_ir_out[11:10];
        w_st = (i_ir_out[15:12] == OP_ST);
        if (i_ir_out[15:12] == OP_HLT) begin
          w_state      = S_HALT;
          w_ctl.halted = 1'b1;
        end else begin
          w_state = S_EX1;
          w_ctl   = f_exec(i_ir_out, i_alu_out_flag[3]);
        end
      end
      S_EX1: begin
        if (r_st) begin
          w_state = S_EX2;
          w_ctl   = f_store(r_rd);
        end else begin
          w_to_fetch = 1'b1;
        end
      end
      S_EX2:  w_to_fetch = 1'b1;
      S_HALT: w_ctl.halted = 1'b1;
      default: begin
        w_state = S_RST;
        w_sub   = 1'b0;
        w_cnt   = RESET_PC;
      end
    endcase

    // r_sub in S_FL marks a fetch that is parked waiting for a step
    if (w_to_fetch) begin
      w_state = S_FL;
`ifdef CU_SINGLE_STEP_EN
      if (i_step) begin
        w_sub = 1'b0;
        w_ctl = f_fetch(1'b0);
      end else begin
        w_sub   = 1'b1;
        w_ready = 1'b1;
      end
`else
      w_sub = 1'b0;
      w_ctl = f_fetch(1'b0);
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_RST;
      r_sub   <= 1'b0;
      r_cnt   <= RESET_PC;
      r_rd    <= 2'b00;
      r_st    <= 1'b0;
      r_ctl   <= f_idle();
`ifdef CU_SINGLE_STEP_EN
      r_ready <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_sub   <= w_sub;
      r_cnt   <= w_cnt;
      r_rd    <= w_rd;
      r_st    <= w_st;
      r_ctl   <= w_ctl;
`ifdef CU_SINGLE_STEP_EN
      r_ready <= w_ready;
`endif
    end
  end

`ifdef CU_SINGLE_STEP_EN
  assign o_ready = r_ready;
`endif

  assign w_unused_bits = ^{i_ir_out[5:0], i_alu_out_flag[2:0]};

  assign o_rf_out_a_sel  = r_ctl.rf_out_a_sel;
  assign o_rf_out_b_sel  = r_ctl.rf_out_b_sel;
  assign o_rf_fun_sel    = r_ctl.rf_fun_sel;
  assign o_rf_r_sel      = r_ctl.rf_r_sel;
  assign o_rf_t_sel      = 4'b0000;
  assign o_alu_fun_sel   = r_ctl.alu_fun_sel;
  assign o_arf_out_c_sel = r_ctl.arf_out_c_sel;
  assign o_arf_out_d_sel = r_ctl.arf_out_d_sel;
  assign o_arf_fun_sel   = r_ctl.arf_fun_sel;
  assign o_arf_reg_sel   = r_ctl.arf_reg_sel;
  assign o_ir_lh         = r_ctl.ir_lh;
  assign o_ir_enable     = r_ctl.ir_enable;
  assign o_ir_fun_sel    = r_ctl.ir_fun_sel;
  assign o_mem_wr        = r_ctl.mem_wr;
  assign o_mem_cs        = r_ctl.mem_cs;
  assign o_mux_a_sel     = r_ctl.mux_a_sel;
  assign o_mux_b_sel     = r_ctl.mux_b_sel;
  assign o_mux_c_sel     = r_ctl.mux_c_sel;
  assign o_halted        = r_ctl.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-instruction control vectors checked each cycle,
// plus hand-written reset, store, and halt sequences. Built with RESET_PC = 3.
module tb_control_sequencer;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] rf_fun;
    logic [3:0] rsel;
    logic [3:0] tsel;
    logic [3:0] alu;
    logic [1:0] out_c;
    logic [1:0] out_d;
    logic [1:0] arf_fun;
    logic [3:0] arf_reg;
    logic       ir_lh;
    logic       ir_en;
    logic [1:0] ir_fun;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
    logic       halted;
  } ctl_t;

  typedef struct packed {
    logic [15:0] ir;
    logic [3:0]  fl;
    ctl_t        exp;
  } vec_t;

  localparam int NVEC = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir_out;
  logic [3:0]  flags;
  logic [2:0]  rf_out_a_sel, rf_out_b_sel;
  logic [1:0]  rf_fun_sel, arf_out_c_sel, arf_out_d_sel, arf_fun_sel, ir_fun_sel;
  logic [3:0]  rf_r_sel, rf_t_sel, alu_fun_sel, arf_reg_sel;
  logic        ir_lh, ir_enable, mem_wr, mem_cs, mux_c_sel, halted;
  logic [1:0]  mux_a_sel, mux_b_sel;
`ifdef CU_SINGLE_STEP_EN
  logic        ready;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  control_sequencer #(.RESET_PC(8'h03)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
`ifdef CU_SINGLE_STEP_EN
    .i_step          (1'b1),
    .o_ready         (ready),
`endif
    .i_ir_out        (ir_out),
    .i_alu_out_flag  (flags),
    .o_rf_out_a_sel  (rf_out_a_sel),
    .o_rf_out_b_sel  (rf_out_b_sel),
    .o_rf_fun_sel    (rf_fun_sel),
    .o_rf_r_sel      (rf_r_sel),
    .o_rf_t_sel      (rf_t_sel),
    .o_alu_fun_sel   (alu_fun_sel),
    .o_arf_out_c_sel (arf_out_c_sel),
    .o_arf_out_d_sel (arf_out_d_sel),
    .o_arf_fun_sel   (arf_fun_sel),
    .o_arf_reg_sel   (arf_reg_sel),
    .o_ir_lh         (ir_lh),
    .o_ir_enable     (ir_enable),
    .o_ir_fun_sel    (ir_fun_sel),
    .o_mem_wr        (mem_wr),
    .o_mem_cs        (mem_cs),
    .o_mux_a_sel     (mux_a_sel),
    .o_mux_b_sel     (mux_b_sel),
    .o_mux_c_sel     (mux_c_sel),
    .o_halted        (halted)
  );

  function automatic ctl_t idle();
    ctl_t c;
    c        = '0;
    c.mem_cs = 1'b1;
    return c;
  endfunction

  function automatic ctl_t fetch(input logic lh);
    ctl_t c;
    c         = idle();
    c.out_d   = 2'b10;
    c.mem_cs  = 1'b0;
    c.ir_en   = 1'b1;
    c.ir_lh   = lh;
    c.ir_fun  = 2'b01;
    c.arf_reg = 4'b1000;
    c.arf_fun = 2'b11;
    return c;
  endfunction

  function automatic ctl_t pc_op(input logic [1:0] fun);
    ctl_t c;
    c         = idle();
    c.arf_reg = 4'b1000;
    c.arf_fun = fun;
    return c;
  endfunction

  function automatic ctl_t alu_op(input logic [2:0] a, input logic [2:0] b,
                                  input logic [3:0] rsel, input logic [3:0] alu);
    ctl_t c;
    c        = idle();
    c.a      = a;
    c.b      = b;
    c.rf_fun = 2'b01;
    c.rsel   = rsel;
    c.alu    = alu;
    return c;
  endfunction

  function automatic ctl_t rf_ld(input logic [3:0] rsel, input logic [1:0] mux_a);
    ctl_t c;
    c        = idle();
    c.rf_fun = 2'b01;
    c.rsel   = rsel;
    c.mux_a  = mux_a;
    return c;
  endfunction

  function automatic ctl_t ldm(input logic [3:0] rsel);
    ctl_t c;
    c        = rf_ld(rsel, 2'b01);
    c.mem_cs = 1'b0;
    c.out_d  = 2'b00;
    return c;
  endfunction

  function automatic ctl_t arf_ld(input logic [3:0] sel);
    ctl_t c;
    c         = idle();
    c.arf_reg = sel;
    c.arf_fun = 2'b01;
    c.mux_b   = 2'b10;
    return c;
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.a       = rf_out_a_sel;
    c.b       = rf_out_b_sel;
    c.rf_fun  = rf_fun_sel;
    c.rsel    = rf_r_sel;
    c.tsel    = rf_t_sel;
    c.alu     = alu_fun_sel;
    c.out_c   = arf_out_c_sel;
    c.out_d   = arf_out_d_sel;
    c.arf_fun = arf_fun_sel;
    c.arf_reg = arf_reg_sel;
    c.ir_lh   = ir_lh;
    c.ir_en   = ir_enable;
    c.ir_fun  = ir_fun_sel;
    c.mem_wr  = mem_wr;
    c.mem_cs  = mem_cs;
    c.mux_a   = mux_a_sel;
    c.mux_b   = mux_b_sel;
    c.mux_c   = mux_c_sel;
    c.halted  = halted;
    return c;
  endfunction

  task automatic check(input string nm, input ctl_t exp);
    ctl_t act;
    act = sample();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called on the negedge where rst is released; returns at the first fetch-low sample.
  task automatic boot(input string tag);
    rst = 1'b0;
    @(negedge clk);
    check({tag, "_pc_clear"}, pc_op(2'b00));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("%s_pc_inc%0d", tag, k), pc_op(2'b11));
    end
    @(negedge clk);
  endtask

  // Entered at a fetch-low sample; leaves at the next instruction's fetch-low sample.
  task automatic run_instr(input logic [15:0] ir, input logic [3:0] fl,
                           input ctl_t exp, input string tag);
    ir_out = ir;
    flags  = fl;
    check({tag, "_fl"}, fetch(1'b0));
    @(negedge clk);
    check({tag, "_fh"}, fetch(1'b1));
    @(negedge clk);
    check({tag, "_dec"}, idle());
    @(negedge clk);
    check({tag, "_ex1"}, exp);
    @(negedge clk);
  endtask

  initial begin
    ctl_t st_ex1, st_ex2, halt_c;
    ir_out = 16'h0000;
    flags  = 4'h0;

    vecs[0]  = '{16'hB405, 4'h0, rf_ld(4'b0100, 2'b10)};
    vecs[1]  = '{16'hB003, 4'h0, rf_ld(4'b1000, 2'b10)};
    vecs[2]  = '{16'hB404, 4'h0, rf_ld(4'b0100, 2'b10)};
    vecs[3]  = '{16'h3840, 4'h0, alu_op(3'd0, 3'd1, 4'b0010, 4'b0100)};
    vecs[4]  = '{16'h0E40, 4'h0, alu_op(3'd2, 3'd1, 4'b0001, 4'b0111)};
    vecs[5]  = '{16'h43C0, 4'h0, alu_op(3'd3, 3'd3, 4'b1000, 4'b0110)};
    vecs[6]  = '{16'h8400, 4'h0, alu_op(3'd0, 3'd0, 4'b0100, 4'b1101)};
    vecs[7]  = '{16'h6900, 4'h0, alu_op(3'd1, 3'd0, 4'b0010, 4'b1010)};
    vecs[8]  = '{16'h10C0, 4'h0, alu_op(3'd0, 3'd3, 4'b1000, 4'b1000)};
    vecs[9]  = '{16'h2600, 4'h0, alu_op(3'd2, 3'd0, 4'b0100, 4'b0010)};
    vecs[10] = '{16'h5C00, 4'h0, alu_op(3'd0, 3'd0, 4'b0001, 4'b1011)};
    vecs[11] = '{16'h7100, 4'h0, alu_op(3'd1, 3'd0, 4'b1000, 4'b1100)};
    vecs[12] = '{16'hA020, 4'h8, idle()};
    vecs[13] = '{16'hA020, 4'h4, arf_ld(4'b1000)};
    vecs[14] = '{16'h907F, 4'h8, arf_ld(4'b1000)};
    vecs[15] = '{16'hCC00, 4'h0, ldm(4'b0001)};
    vecs[16] = '{16'hE040, 4'h0, arf_ld(4'b0100)};

    st_ex1       = idle();
    st_ex1.a     = 3'd2;
    st_ex2       = st_ex1;
    st_ex2.mem_cs = 1'b0;
    st_ex2.mem_wr = 1'b1;
    st_ex2.out_d  = 2'b00;
    halt_c        = idle();
    halt_c.halted = 1'b1;

    @(negedge clk);
    check("reset_idle", idle());
    boot("boot");

    for (int i = 0; i < NVEC; i++)
      run_instr(vecs[i].ir, vecs[i].fl, vecs[i].exp, $sformatf("v%0d", i));

    // reset in the middle of the high-byte fetch
    ir_out = 16'hB405;
    check("fh_rst_fl", fetch(1'b0));
    @(negedge clk);
    check("fh_rst_fh", fetch(1'b1));
    rst = 1'b1;
    #1;
    check("fh_rst_async_idle", idle());
    @(negedge clk);
    boot("reboot1");
    run_instr(16'hB405, 4'h0, rf_ld(4'b0100, 2'b10), "after_fh_rst");

    // MAR 0x40 then ST R3: two execute cycles, five in total
    run_instr(16'hE040, 4'h0, arf_ld(4'b0100), "mar40");
    run_instr(16'hD800, 4'h0, st_ex1, "st");
    check("st_ex2", st_ex2);
    @(negedge clk);
    check("st_next_fl", fetch(1'b0));

    // reset landing on the store write cycle must drop the strobe immediately
    ir_out = 16'hD800;
    repeat (3) @(negedge clk);
    check("st_rst_ex1", st_ex1);
    @(negedge clk);
    check("st_rst_ex2", st_ex2);
    rst = 1'b1;
    #1;
    check("st_rst_async_idle", idle());
    @(negedge clk);
    boot("reboot2");

    // halt stays halted and idle
    ir_out = 16'hF000;
    check("hlt_fl", fetch(1'b0));
    @(negedge clk);
    check("hlt_fh", fetch(1'b1));
    @(negedge clk);
    check("hlt_dec", idle());
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      check($sformatf("halted%0d", k), halt_c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
